// File: rtl/word_assembler.sv
// Byte-to-word assembler: collects N=W/B bytes LSB-first, then pulses out_en.
// Define WORD_ASSEMBLER_PARITY_EN to add the out_par output.
module word_assembler #(
   parameter int W = 32,
   parameter int B = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [B-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         flush,
   input  logic         out_hold,
   output logic [W-1:0] out_data,
`ifdef WORD_ASSEMBLER_PARITY_EN
   output logic         out_par,
`endif
   output logic         out_en
);

   localparam int N  = W / B;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {FILL, FULL} state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [W-1:0]   data, data_nx;
   logic           accept;

   assign in_ready = (state == FILL) && !flush && !rst;
   assign out_en   = (state == FULL) && !out_hold && !rst;
   assign accept   = in_valid && in_ready;
   assign out_data = data;

`ifdef WORD_ASSEMBLER_PARITY_EN
   assign out_par = ^data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
         cnt   <= '0;
         data  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         data  <= data_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      data_nx  = data;
      unique case (state)
         FILL: begin
            // flush drops the slot position only; stale bytes get overwritten
            if (flush) begin
               cnt_nx = '0;
            end else if (accept) begin
               for (int i = 0; i < N; i++) begin
                  if (cnt == CW'(i)) data_nx[i*B +: B] = in_data;
               end
               if (cnt == CW'(N - 1)) begin
                  cnt_nx   = '0;
                  state_nx = FULL;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
         end
         FULL: begin
            if (!out_hold) state_nx = FILL;
         end
         default: state_nx = FILL;
      endcase
   end

endmodule

// File: tb/tb_word_assembler.sv
// Randomized and directed bench for word_assembler (W=32, B=8).
// A queue-based model predicts handshakes, held data and delivered words.
module tb_word_assembler;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic        out_hold;
   logic [31:0] out_data;
   logic        out_en;
`ifdef WORD_ASSEMBLER_PARITY_EN
   logic        out_par;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   word_assembler #(.W(32), .B(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .flush    (flush),
      .out_hold (out_hold),
      .out_data (out_data),
`ifdef WORD_ASSEMBLER_PARITY_EN
      .out_par  (out_par),
`endif
      .out_en   (out_en)
   );

   always #5 clk = ~clk;

   // Model: collected bytes, a pending completed word, and the register image.
   byte unsigned  m_bytes[$];
   bit            m_full  = 1'b0;
   bit            m_init  = 1'b0;
   logic [31:0]   m_image = '0;
   logic [31:0]   exp_q[$];
   int            delivered = 0;

   function automatic logic [31:0] pack_word(input byte unsigned b[$]);
      return {b[3], b[2], b[1], b[0]};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         if (m_full && exp_q.size() > 0) void'(exp_q.pop_back());
         m_full  = 1'b0;
         m_bytes.delete();
         m_image = '0;
         m_init  = 1'b1;
      end else if (m_full) begin
         if (!out_hold) m_full = 1'b0;
      end else if (flush) begin
         m_bytes.delete();
      end else if (in_valid) begin
         m_bytes.push_back(in_data);
         m_image[(m_bytes.size()-1)*8 +: 8] = in_data;
         if (m_bytes.size() == 4) begin
            exp_q.push_back(pack_word(m_bytes));
            m_bytes.delete();
            m_full = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   // Per-cycle compare against the model, mid-cycle.
   always @(negedge clk) begin
      logic exp_rdy, exp_en;
      exp_rdy = !m_full && !flush && !rst;
      exp_en  = m_full && !out_hold && !rst;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("out_en", {31'd0, out_en}, {31'd0, exp_en});
      if (m_init) begin
         chk("out_data", out_data, m_image);
`ifdef WORD_ASSEMBLER_PARITY_EN
         chk("out_par", {31'd0, out_par}, {31'd0, ^m_image});
`endif
      end
      if (out_en === 1'b1 && exp_en) begin
         if (exp_q.size() == 0) begin
            chk("word_unexpected", out_data, 32'hxxxxxxxx);
         end else begin
            chk("word_order", out_data, exp_q.pop_front());
         end
         delivered++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      flush    = 1'b0;
      out_hold = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
   endtask

   initial begin
      int target;
      int cycles;
      byte unsigned nxt;
      rst = 1'b1;
      in_data = '0;
      idle();
      tick();
      tick();
      chk("reset_data", out_data, 32'h0);
      chk("reset_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      tick();
      chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

      // Basic word, no backpressure.
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      idle();
      #1;
      chk("w1_en", {31'd0, out_en}, 32'd1);
      chk("w1_data", out_data, 32'h44332211);
      chk("w1_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("w1_en_drop", {31'd0, out_en}, 32'd0);
      chk("w1_ready_back", {31'd0, in_ready}, 32'd1);

      // Held word.
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
      in_valid = 1'b1;
      in_data  = 8'h55;
      out_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_en", {31'd0, out_en}, 32'd0);
         chk("hold_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_data", out_data, 32'hDEADBEEF);
         tick();
      end
      idle();
      #1;
      chk("hold_release_en", {31'd0, out_en}, 32'd1);
      tick();
      chk("hold_single_pulse", {31'd0, out_en}, 32'd0);

      // Flush discards the partial word and the byte offered with it.
      send(8'hAA); send(8'hBB);
      flush = 1'b1;
      in_valid = 1'b1;
      in_data = 8'hCC;
      #1;
      chk("flush_ready", {31'd0, in_ready}, 32'd0);
      tick();
      flush = 1'b0;
      chk("flush_keeps_data", out_data, 32'hDEADBBAA);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      idle();
      #1;
      chk("flush_word", out_data, 32'h04030201);
      chk("flush_word_en", {31'd0, out_en}, 32'd1);
      tick();

      // Reset mid-word.
      send(8'hA1); send(8'hA2); send(8'hA3);
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_mid_data", out_data, 32'h0);
      chk("rst_mid_en", {31'd0, out_en}, 32'd0);
      tick();
      send(8'h10); send(8'h20); send(8'h30); send(8'h40);
      idle();
      #1;
      chk("fresh_word", out_data, 32'h40302010);
      tick();

`ifdef WORD_ASSEMBLER_PARITY_EN
      send(8'h07); send(8'h00); send(8'h00); send(8'h00);
      idle();
      #1;
      chk("par_7", {31'd0, out_par}, 32'd1);
      tick();
      send(8'h03); send(8'h00); send(8'h00); send(8'h00);
      idle();
      #1;
      chk("par_3", {31'd0, out_par}, 32'd0);
      tick();
`endif

      // Random traffic: byte sequence advances only on acceptance.
      target = delivered + 100;
      cycles = 0;
      nxt = 8'(($urandom % 200) + 1);
      while (delivered < target && cycles < 20000) begin
         in_valid = ($urandom % 2) == 0;
         in_data  = nxt;
         out_hold = ($urandom % 3) == 0;
         flush    = 1'b0;
         #1;
         if (in_valid && in_ready) nxt = nxt + 8'd1;
         @(posedge clk);
         #1;
         cycles++;
      end
      idle();
      tick();
      tick();
      chk("random_delivered", delivered, target);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
